// File: rtl/seg_display_pkg.sv
// Shared definitions for the serial 7-segment display driver.
//   state_e      : controller states
//   SEG_*        : fixed segment codes, byte layout {dp,g,f,e,d,c,b,a}, active-high
//   hex_to_seg() : nibble -> segment byte (0-9, A-F), dp always 0
package seg_display_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_R     = 8'h50;
  localparam logic [7:0] SEG_E     = 8'h79;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_frame_builder.sv
// Combinational frame builder: turns a magnitude, sign flag and error flag
// into the full segment frame for the display chain.
//   i_data   : unsigned magnitude, hex digit i at bits [4i+3:4i]
//   i_neg    : show a minus sign just left of the most significant digit
//   i_error  : show "Err" (overrides data and sign)
//   o_frame  : byte i drives digit i (digit 0 rightmost)
module seg_frame_builder
  import seg_display_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_neg,
  input  logic                    i_error,
  output logic [8*NUM_DIGITS-1:0] o_frame
);

  localparam int NIB = DATA_WIDTH / 4;

  int k;  // significant-digit count, never less than 1

  always_comb begin
    k = 1;
    for (int i = 0; i < NIB; i++) begin
      if (i_data[4*i +: 4] != 4'h0) k = i + 1;
    end

    o_frame = '0;
    // A sign that would fall off the left end is unrepresentable -> "Err".
    if (i_error || (i_neg && (k >= NUM_DIGITS))) begin
      o_frame[23:16] = SEG_E;
      o_frame[15:8]  = SEG_R;
      o_frame[7:0]   = SEG_R;
    end else begin
      for (int i = 0; i < NIB; i++) begin
        if (i < k) o_frame[8*i +: 8] = hex_to_seg(i_data[4*i +: 4]);
      end
      if (i_neg) o_frame[8*k +: 8] = SEG_MINUS;
    end
  end

endmodule

// File: rtl/seg_sr_display_driver.sv
// Serial driver for a chain of NUM_DIGITS 7-segment shift registers
// (e.g. 74HC595). After reset it flushes an all-blank frame, then accepts
// one value per handshake and shifts its frame out followed by a latch pulse.
//   clk, rst       : system clock, synchronous active-high reset
//   i_data         : magnitude to display
//   i_data_is_neg  : show minus sign
//   i_error        : show "Err"
//   i_valid        : request; accepted when o_ready=1
//   o_ready        : idle, a request is taken on the next rising edge
//   o_sr_data      : serial data, leftmost digit first, dp bit first
//   o_sr_clk       : shift clock, low then high for CLK_DIV cycles each per bit
//   o_sr_latch     : storage latch, high for CLK_DIV cycles after the last bit
module seg_sr_display_driver
  import seg_display_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_is_neg,
  input  logic                  i_error,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sr_data,
  output logic                  o_sr_clk,
  output logic                  o_sr_latch
);

  localparam int FRAME_W = 8 * NUM_DIGITS;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e                state_q, state_d;
  logic [FRAME_W-1:0]    sr_q, sr_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  phase_q, phase_d;   // current o_sr_clk level
  logic                  latch_q, latch_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  neg_q, neg_d;
  logic                  err_q, err_d;
  logic [FRAME_W-1:0]    frame;

  seg_frame_builder #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_frame (
    .i_data  (data_q),
    .i_neg   (neg_q),
    .i_error (err_q),
    .o_frame (frame)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    latch_d   = latch_q;
    ready_d   = ready_q;
    data_d    = data_q;
    neg_d     = neg_q;
    err_d     = err_q;

    case (state_q)
      // INIT plays the role of LOAD with a blank frame, so the power-up
      // flush takes exactly as long as a normal transfer.
      ST_INIT: begin
        sr_d      = '0;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        phase_d   = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_IDLE: begin
        if (i_valid) begin
          data_d  = i_data;
          neg_d   = i_data_is_neg;
          err_d   = i_error;
          ready_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_d      = frame;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        phase_d   = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of bit: drop the clock and present the next bit together,
            // the register already sampled on the rising edge.
            phase_d = 1'b0;
            sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              latch_d   = 1'b1;
              state_d   = ST_LATCH;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          latch_d   = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
      latch_q   <= 1'b0;
      ready_q   <= 1'b0;
      data_q    <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      latch_q   <= latch_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
    end
  end

  // The shift register shifts in zeros, so its MSB is 0 outside SHIFT.
  assign o_sr_data  = sr_q[FRAME_W-1];
  assign o_sr_clk   = phase_q;
  assign o_sr_latch = latch_q;
  assign o_ready    = ready_q;

endmodule

// File: tb/tb_seg_sr_display_driver.sv
module tb_seg_sr_display_driver;

  localparam int NU = 3;
  localparam int ND [NU] = '{5, 4, 5};
  localparam int CD [NU] = '{1, 1, 3};
  localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NU];
  logic        vld [NU];
  logic [15:0] dat [NU];
  logic        neg [NU];
  logic        err [NU];
  logic        rdy [NU];
  logic        sdat [NU];
  logic        sclk [NU];
  logic        slat [NU];

  int checks = 0;
  int errors = 0;

  seg_sr_display_driver #(.DATA_WIDTH(16), .NUM_DIGITS(5), .CLK_DIV(1)) dut0 (
    .clk(clk), .rst(rst[0]), .i_data(dat[0]), .i_data_is_neg(neg[0]), .i_error(err[0]),
    .i_valid(vld[0]), .o_ready(rdy[0]), .o_sr_data(sdat[0]), .o_sr_clk(sclk[0]),
    .o_sr_latch(slat[0]));
  seg_sr_display_driver #(.DATA_WIDTH(16), .NUM_DIGITS(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst[1]), .i_data(dat[1]), .i_data_is_neg(neg[1]), .i_error(err[1]),
    .i_valid(vld[1]), .o_ready(rdy[1]), .o_sr_data(sdat[1]), .o_sr_clk(sclk[1]),
    .o_sr_latch(slat[1]));
  seg_sr_display_driver #(.DATA_WIDTH(16), .NUM_DIGITS(5), .CLK_DIV(3)) dut2 (
    .clk(clk), .rst(rst[2]), .i_data(dat[2]), .i_data_is_neg(neg[2]), .i_error(err[2]),
    .i_valid(vld[2]), .o_ready(rdy[2]), .o_sr_data(sdat[2]), .o_sr_clk(sclk[2]),
    .o_sr_latch(slat[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Display model: digit count from magnitude range, codes from a table.
  function automatic logic [39:0] mk_frame(input int nd, input logic [15:0] d,
                                           input logic n, input logic e);
    logic [39:0] f;
    int k;
    f = '0;
    k = 1;
    while (k < 4 && int'(d) >= (1 << (4 * k))) k++;
    if (e || (n && k >= nd)) begin
      f[23:0] = {8'h79, 8'h50, 8'h50};
    end else begin
      for (int i = 0; i < k; i++) f[8*i +: 8] = HEX[(int'(d) >> (4 * i)) & 15];
      if (n) f[8*k +: 8] = 8'h40;
    end
    return f;
  endfunction

  // Timeline model: age = edges since the start edge (transfer or reset).
  int          m_age  [NU];
  bit          m_busy [NU];
  logic [39:0] m_frame[NU];

  initial begin
    for (int u = 0; u < NU; u++) begin
      m_age[u] = 0; m_busy[u] = 1'b1; m_frame[u] = '0;
    end
  end

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rst[u]) begin
        m_age[u] = 0; m_busy[u] = 1'b1; m_frame[u] = '0;
      end else if (m_busy[u]) begin
        m_age[u]++;
        if (m_age[u] == 1 + 16 * CD[u] * ND[u] + CD[u]) m_busy[u] = 1'b0;
      end else if (vld[u]) begin
        m_frame[u] = mk_frame(ND[u], dat[u], neg[u], err[u]);
        m_age[u] = 0; m_busy[u] = 1'b1;
      end
    end
  end

  // Emulated external register chain, driven by the DUT pins.
  logic [39:0] x_sr   [NU];
  logic [39:0] x_disp [NU];
  logic        p_clk  [NU];
  logic        p_lat  [NU];
  int          lat_cnt[NU];
  int          lat_run[NU];
  int          lat_len[NU];

  initial begin
    for (int u = 0; u < NU; u++) begin
      x_sr[u] = '0; x_disp[u] = '0; p_clk[u] = 1'b0; p_lat[u] = 1'b0;
      lat_cnt[u] = 0; lat_run[u] = 0; lat_len[u] = 0;
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      logic e_rdy, e_dat, e_clk, e_lat;
      int shift_cyc, s, b;
      shift_cyc = 16 * CD[u] * ND[u];
      e_rdy = !m_busy[u];
      e_dat = 1'b0; e_clk = 1'b0; e_lat = 1'b0;
      if (m_busy[u] && m_age[u] >= 1 && m_age[u] < 1 + shift_cyc) begin
        s = m_age[u] - 1;
        b = s / (2 * CD[u]);
        e_clk = (s % (2 * CD[u])) >= CD[u];
        e_dat = m_frame[u][8 * ND[u] - 1 - b];
      end
      if (m_busy[u] && m_age[u] >= 1 + shift_cyc) e_lat = 1'b1;
      chk($sformatf("cycle u%0d o_ready", u), 64'(rdy[u]), 64'(e_rdy));
      chk($sformatf("cycle u%0d o_sr_data", u), 64'(sdat[u]), 64'(e_dat));
      chk($sformatf("cycle u%0d o_sr_clk", u), 64'(sclk[u]), 64'(e_clk));
      chk($sformatf("cycle u%0d o_sr_latch", u), 64'(slat[u]), 64'(e_lat));

      if (sclk[u] === 1'b1 && p_clk[u] === 1'b0) x_sr[u] = {x_sr[u][38:0], sdat[u]};
      if (slat[u] === 1'b1 && p_lat[u] === 1'b0) begin
        x_disp[u] = x_sr[u] & ((40'd1 << (8 * ND[u])) - 40'd1);
        lat_cnt[u]++;
        lat_run[u] = 0;
      end
      if (slat[u] === 1'b1) lat_run[u]++;
      else if (p_lat[u] === 1'b1) lat_len[u] = lat_run[u];
      p_clk[u] = sclk[u];
      p_lat[u] = slat[u];
    end
  end

  task automatic wait_ready(input int u, output int n);
    n = 0;
    while (rdy[u] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
  endtask

  task automatic run_case(input string name, input int u, input logic [15:0] d,
                          input logic n, input logic e, input logic [39:0] exp,
                          input int exp_busy);
    int busy, lc;
    lc = lat_cnt[u];
    chk({name, " model frame"}, 64'(mk_frame(ND[u], d, n, e)), 64'(exp));
    @(negedge clk);
    dat[u] = d; neg[u] = n; err[u] = e; vld[u] = 1'b1;
    @(negedge clk);
    vld[u] = 1'b0;
    wait_ready(u, busy);
    chk({name, " busy cycles"}, 64'(busy), 64'(exp_busy));
    chk({name, " latched frame"}, 64'(x_disp[u]), 64'(exp));
    chk({name, " latch pulses"}, 64'(lat_cnt[u] - lc), 64'd1);
    chk({name, " latch width"}, 64'(lat_len[u]), 64'(CD[u]));
  endtask

  initial begin
    int t [NU];
    int n, lc;
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; vld[u] = 1'b0; dat[u] = '0; neg[u] = 1'b0; err[u] = 1'b0; t[u] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset o_ready", 64'(rdy[0]), 64'd0);
    chk("reset o_sr_clk", 64'(sclk[0]), 64'd0);
    chk("reset o_sr_latch", 64'(slat[2]), 64'd0);
    chk("reset o_sr_data", 64'(sdat[1]), 64'd0);

    for (int u = 0; u < NU; u++) rst[u] = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) if (rdy[u] === 1'b1 && t[u] == 0) t[u] = k;
    end
    #1;
    chk("flush busy u0", 64'(t[0]), 64'd82);
    chk("flush busy u1", 64'(t[1]), 64'd66);
    chk("flush busy u2", 64'(t[2]), 64'd244);
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("flush frame u%0d", u), 64'(x_disp[u]), 64'd0);
      chk($sformatf("flush latch pulses u%0d", u), 64'(lat_cnt[u]), 64'd1);
    end

    run_case("a3",          0, 16'h00A3, 1'b0, 1'b0, 40'h00_00_00_77_4F, 82);
    run_case("a3 neg",      0, 16'h00A3, 1'b1, 1'b0, 40'h00_00_40_77_4F, 82);
    run_case("zero neg",    0, 16'h0000, 1'b1, 1'b0, 40'h00_00_00_40_3F, 82);
    run_case("zero",        0, 16'h0000, 1'b0, 1'b0, 40'h00_00_00_00_3F, 82);
    run_case("error",       0, 16'h1234, 1'b1, 1'b1, 40'h00_00_79_50_50, 82);
    run_case("1234 neg",    0, 16'h1234, 1'b1, 1'b0, 40'h40_06_5B_4F_66, 82);
    run_case("f00 neg",     0, 16'h0F00, 1'b1, 1'b0, 40'h00_40_71_3F_3F, 82);
    run_case("nd4 ffff neg",1, 16'hFFFF, 1'b1, 1'b0, 40'h00_00_79_50_50, 66);
    run_case("nd4 123 neg", 1, 16'h0123, 1'b1, 1'b0, 40'h00_40_06_5B_4F, 66);
    run_case("nd4 beef",    1, 16'hBEEF, 1'b0, 1'b0, 40'h00_7C_79_79_71, 66);
    run_case("cd3 ffff",    2, 16'hFFFF, 1'b0, 1'b0, 40'h00_71_71_71_71, 244);
    run_case("cd3 8 neg",   2, 16'h0008, 1'b1, 1'b0, 40'h00_00_00_40_7F, 244);

    // Reset around bit 20 of a frame: no latch, then a blank flush.
    lc = lat_cnt[0];
    @(negedge clk);
    dat[0] = 16'h1234; neg[0] = 1'b0; err[0] = 1'b0; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (41) @(negedge clk);
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    wait_ready(0, n);
    chk("abort flush busy", 64'(n), 64'd82);
    chk("abort latch pulses", 64'(lat_cnt[0] - lc), 64'd1);
    chk("abort flush frame", 64'(x_disp[0]), 64'd0);

    // Back-to-back: valid held, data changed while busy.
    lc = lat_cnt[0];
    @(negedge clk);
    dat[0] = 16'h00A3; neg[0] = 1'b0; err[0] = 1'b0; vld[0] = 1'b1;
    @(negedge clk);
    chk("b2b first taken", 64'(rdy[0]), 64'd0);
    dat[0] = 16'h0BAD;
    wait_ready(0, n);
    chk("b2b first busy", 64'(n), 64'd82);
    chk("b2b first frame", 64'(x_disp[0]), 64'h00_00_00_77_4F);
    @(negedge clk);
    chk("b2b second taken at once", 64'(rdy[0]), 64'd0);
    vld[0] = 1'b0;
    wait_ready(0, n);
    chk("b2b second busy", 64'(n), 64'd82);
    chk("b2b second frame", 64'(x_disp[0]), 64'h00_00_7C_77_5E);
    chk("b2b latch pulses", 64'(lat_cnt[0] - lc), 64'd2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
